// File: rtl/pipelined_adder_sub_if.sv
// Handshake and operand/result bundle for pipelined_adder_sub.
// The master side supplies operands and consumes results.
interface pipelined_adder_sub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             Sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
   logic             Ovf;
   logic             Zero;

   modport master (
      output in_valid, A, B, Cin, Sub, out_ready,
      input  in_ready, out_valid, Sum, Cout, Ovf, Zero
   );

   modport slave (
      input  in_valid, A, B, Cin, Sub, out_ready,
      output in_ready, out_valid, Sum, Cout, Ovf, Zero
   );
endinterface

// File: rtl/pipelined_adder_sub.sv
// Pipelined WIDTH-bit add/subtract. The carry chain is cut into SEG-bit stages.
// Operands, partial sums and carries shift together, and the whole pipe stalls as one unit.
module pipelined_adder_sub #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   pipelined_adder_sub_if.slave  bus
);
   localparam int STAGES = WIDTH / SEG;

   logic [STAGES-1:0][WIDTH-1:0] a_d, a_q, b_d, b_q, s_d, s_q;
   logic [STAGES-1:0]            c_d, c_q, vld_d, vld_q;
   logic                         ovf_d, ovf_q, zero_d, zero_q;
   logic                         stall;

   assign stall        = vld_q[STAGES-1] && !bus.out_ready;
   assign bus.in_ready = !stall;

   // Stage k consumes slice k. Upper operand slices and lower sum slices are carried along unchanged.
   // B and Cin are mode-adjusted once at entry, so later stages are all plain adders.
   always_comb begin
      logic [WIDTH-1:0] a_in, b_in, s_in;
      logic             c_in;
      logic [SEG:0]     seg;
      int               km1;
      a_d   = '0;
      b_d   = '0;
      s_d   = '0;
      c_d   = '0;
      vld_d = '0;
      a_in  = '0;
      b_in  = '0;
      s_in  = '0;
      c_in  = 1'b0;
      seg   = '0;
      km1   = 0;
      for (int k = 0; k < STAGES; k++) begin
         km1 = (k == 0) ? 0 : k - 1;
         if (k == 0) begin
            a_in     = bus.A;
            b_in     = bus.B ^ {WIDTH{bus.Sub}};
            c_in     = bus.Cin ^ bus.Sub;
            s_in     = '0;
            vld_d[k] = bus.in_valid;
         end else begin
            a_in     = a_q[km1];
            b_in     = b_q[km1];
            c_in     = c_q[km1];
            s_in     = s_q[km1];
            vld_d[k] = vld_q[km1];
         end
         seg = {1'b0, a_in[k*SEG +: SEG]} + {1'b0, b_in[k*SEG +: SEG]} + {{SEG{1'b0}}, c_in};
         s_in[k*SEG +: SEG] = seg[SEG-1:0];
         a_d[k] = a_in;
         b_d[k] = b_in;
         s_d[k] = s_in;
         c_d[k] = seg[SEG];
      end
      // After the loop, a_in, b_in and s_in hold the last stage's values.
      // The carry into the MSB is recovered as a^b^s at that bit.
      ovf_d  = a_in[WIDTH-1] ^ b_in[WIDTH-1] ^ s_in[WIDTH-1] ^ seg[SEG];
      zero_d = (s_in == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= '0;
         c_q    <= '0;
         vld_q  <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b1;
      end else if (!stall) begin
         a_q    <= a_d;
         b_q    <= b_d;
         s_q    <= s_d;
         c_q    <= c_d;
         vld_q  <= vld_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.Sum       = s_q[STAGES-1];
   assign bus.Cout      = c_q[STAGES-1];
   assign bus.Ovf       = ovf_q;
   assign bus.Zero      = zero_q;
endmodule

// File: doc/pipelined_adder_sub.md
# pipelined_adder_sub

Parametrised, pipelined two's-complement adder/subtractor. It extends the 4-bit ripple adder to WIDTH bits and adds a subtract mode, carry/borrow in, signed overflow and zero flags. A carry chain broken into SEG-bit register stages closes timing at wide widths. It sits in the datapath between operand registers and the result consumer, and uses a valid/ready handshake with whole-pipe stall.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG. SEG = WIDTH gives a single stage.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present this cycle.
- in_ready  output  1  pipe can accept an operand this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in in add mode; borrow-in in subtract mode.
- Sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry-out. In subtract mode this is the inverted borrow (1 = no borrow).
- Ovf  output  1  signed overflow.
- Zero  output  1  Sum == 0.

## Operation
- Add mode: {Cout,Sum} = A + B + Cin.
- Subtract mode: {Cout,Sum} = A + ~B + ~Cin, i.e. A − B − Cin modulo 2^WIDTH.
  - Sub=1, Cin=0 gives plain A − B.
  - Cout=1 means A ≥ B + Cin (unsigned).
- Ovf = carry into MSB XOR carry out of MSB. This equals signed overflow of the effective operation.
- Zero is computed from the final Sum; it is not an early-out.
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] using the registered carry from stage k-1. Stage 0 uses the mode-adjusted Cin.
- Unconsumed upper operand slices and completed lower Sum slices travel with the transaction in skew registers. All slices of one result emerge together.
- Each stage has a valid bit. Stage 0 loads when in_valid && in_ready.
- Stall: stall = out_valid && !out_ready. While stall=1:
  - every pipeline register, valid bits included, holds;
  - in_ready = 0.
- When stall=0:
  - all stages advance one position;
  - in_ready = 1;
  - bubbles (valid=0) advance like data.
- Outputs are registered from the last stage. Sum, Cout, Ovf and Zero are meaningful only when out_valid=1. They hold stable while stalled.
- A transfer happens on any cycle with out_valid && out_ready. Order is strictly FIFO. No transaction is dropped or duplicated.
- Reset mid-operation: all in-flight transactions are discarded. No partial result appears after reset is released.

## Timing
- Latency: STAGES cycles from the accepting edge to out_valid=1, with no stalls. STAGES=4 at default parameters.
- Throughput: one result per cycle when out_ready is held at 1.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid to in_ready.
- Reset values:
  - all valid bits = 0, so out_valid = 0;
  - Sum = 0, Cout = 0, Ovf = 0;
  - Zero = 1 (consistent with Sum = 0);
  - in_ready = 1.
- Reset assertion clears state immediately, without waiting for a clock edge. The first accept is possible on the first rising edge after rst deasserts.
- Simultaneous transfer at output and accept at input under stall=0 is legal and loses nothing.
- When SEG = WIDTH, latency is 1 and behaviour is otherwise identical.

## Test plan
All cases at WIDTH=16, SEG=4.
- Reset: hold rst with random inputs -> out_valid=0, Sum=0, Zero=1, in_ready=1. Assert rst asynchronously mid-stream -> out_valid drops before the next edge, and no stale result appears after release.
- Carry ripple across all stages: A=0xFFFF, B=0x0000, Cin=1, Sub=0 -> 4 cycles later Sum=0x0000, Cout=1, Ovf=0, Zero=1.
- Signed overflow, add: A=0x7FFF, B=0x0001, Sub=0, Cin=0 -> Sum=0x8000, Cout=0, Ovf=1.
- Subtract with borrow: A=0x0003, B=0x0005, Sub=1, Cin=0 -> Sum=0xFFFE, Cout=0, Ovf=0.
- Subtract with borrow-in: A=0x8000, B=0x0001, Sub=1, Cin=1 -> Sum=0x7FFE, Cout=1, Ovf=1.
- Back-to-back throughput and stall:
  - stream 100 random transactions with in_valid=1;
  - toggle out_ready randomly;
  - compare against a reference model -> results arrive in order with none lost or duplicated;
  - outputs are stable while stalled;
  - in_ready=0 exactly when out_valid && !out_ready.
